qam16_tx_modulator: RTL and testbench
=====================================

# qam16_tx_modulator

Transmit-side 16-QAM modulator for the QAM link. It accepts a serial bit stream with a ready/valid handshake and groups the bits into 4-bit symbols. Each symbol is Gray-mapped to I/Q levels and modulated onto a digital carrier at fs/4. The result is a signed passband sample stream, which is the signal the receive-side band-pass filter and demodulator chain consumes.

## Interface
Parameters:
- SPS, 8, samples per symbol. Must be a multiple of 4 and ≥ 4.
- SCALE, 32, amplitude of a unit level. 3*SCALE must be < 2^(OUT_WIDTH-1).
- OUT_WIDTH, 8, width of sample_out (two's complement).

Ports:
- clock, input, 1, system clock; all logic on the rising edge.
- reset, input, 1, synchronous, active-low; 0 on a rising edge resets all state.
- bit_in, input, 1, serial data bit.
- bit_valid, input, 1, bit_in is valid this cycle.
- bit_ready, output, 1, block can accept a bit this cycle.
- sample_out, output, OUT_WIDTH, signed passband sample, registered.
- sample_valid, output, 1, sample_out is a modulated sample.
- symbol_start, output, 1, one-cycle pulse coincident with the first sample of each symbol.

## Operation
- Bit transfer: a bit transfers on an edge where bit_valid && bit_ready.
- Bit assembly: accepted bits shift into a 4-bit register with a 2-bit count (0..3).
  - The first bit received becomes symbol bit 3 (MSB).
  - When the 4th bit is accepted, the assembled symbol goes to the pending register, pending_full is set, and the count wraps to 0.
- bit_ready = (count != 3) || !pending_full. It is registered-state only, with no combinational path from the input.
- Mapping: bits[3:2] → I and bits[1:0] → Q, Gray-coded: 00→-3, 01→-1, 11→+1, 10→+3.
- Carrier at fs/4, with phase p = sample_cnt[1:0]:
  - p=0: I
  - p=1: -Q
  - p=2: -I
  - p=3: +Q
  - Each value is multiplied by SCALE and sign-extended to OUT_WIDTH.
- FSM states:
  - IDLE: on an edge with pending_full, load cur_sym from pending, clear pending_full, set sample_cnt=0, go to RUN.
  - RUN: sample_cnt increments every cycle. At sample_cnt==SPS-1:
    - if pending_full: load the next symbol, set sample_cnt=0, stay in RUN (seamless, no gap);
    - else: go to IDLE.
- Simultaneous events: a pending load and a 4th-bit acceptance can never land on the same edge, because bit_ready is low when count==3 && pending_full.
  - A load on the same edge as bits 1–3 is legal; the shift register and pending register operate independently.
- Output register, updated every cycle:
  - In RUN: sample_out = map(cur_sym, p); sample_valid=1; symbol_start=1 iff sample_cnt==0.
  - In IDLE: sample_out=0, sample_valid=0, symbol_start=0.
- Reset (reset==0 on an edge, including mid-symbol or mid-assembly):
  - state=IDLE; count, sample_cnt, pending_full, cur_sym and shift register cleared; sample_out=0; sample_valid=0; symbol_start=0.
  - bit_ready reads 1 on the cycle after reset.
  - Partially assembled bits are discarded.

## Timing
- Reset values: sample_out=0, sample_valid=0, symbol_start=0, bit_ready=1.
- Latency: 4th bit accepted on edge t → load on edge t+1 → first valid sample visible after edge t+2, with symbol_start=1.
- Each symbol occupies exactly SPS consecutive valid samples.
- Back-to-back symbols produce no valid gap, provided the next pending symbol is complete by the last sample of the current one.
- Underrun: if no pending symbol exists at the end of a symbol, sample_valid drops for at least 1 cycle. Restart follows the latency rule above.
- Sustained input rate: 4 bits per SPS cycles. Faster input is throttled by bit_ready.

## Test plan
- Reset, then bits 0,0,0,0 with valid every cycle (SPS=8, SCALE=32) → after the 2-cycle latency, valid for 8 cycles with samples -96,+96,+96,-96,-96,+96,+96,-96; symbol_start on the first sample only; then valid=0 and sample_out=0.
- Symbol 1011 → samples +96,-32,-96,+32 repeated twice. Symbol 0110 (I=-1, Q=+3) → -32,-96,+32,+96 repeated.
- 12 bits driven continuously (1011 twice, then 0000) → 24 consecutive valid samples with no gap; bit_ready low while count==3 && pending_full; three symbol_start pulses spaced 8 cycles apart.
- Bits with bit_valid toggling 1,0,1,0 → only cycles with valid&&ready are counted; the output matches the same symbols sent without gaps, shifted in time.
- Assert reset during sample 5 of a symbol, with a pending symbol and 2 assembly bits held → the next cycle shows valid=0, sample_out=0, bit_ready=1; the next 4 bits form a fresh symbol and the stale pending symbol is never output.
- Underrun: second symbol completes 3 cycles after the first symbol ends → valid low for ≥1 cycle, then restart with symbol_start and correct first-phase value I*SCALE.

Source files
------------

// File: rtl/qam16_tx_modulator.sv
// 16-QAM transmit modulator: serial bits -> 4-bit Gray-mapped symbols -> fs/4 passband samples.
// Each symbol plays for SPS samples; a pending symbol register lets consecutive symbols run without a gap.
module qam16_tx_modulator #(
  parameter int SPS       = 8,
  parameter int SCALE     = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 bit_ready,
  output logic [OUT_WIDTH-1:0] sample_out,
  output logic                 sample_valid,
  output logic                 symbol_start
);

  localparam int CNT_W = $clog2(SPS);
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(SPS - 1);
  localparam logic signed [OUT_WIDTH-1:0] SCALE_S = OUT_WIDTH'(SCALE);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                       state_q, state_d;
  logic [1:0]                   bcnt_q, bcnt_d;
  logic [2:0]                   shift_q, shift_d;
  logic [3:0]                   pend_q, pend_d;
  logic                         pend_full_q, pend_full_d;
  logic [3:0]                   sym_q, sym_d;
  logic [CNT_W-1:0]             scnt_q, scnt_d;
  logic signed [OUT_WIDTH-1:0]  out_q, out_d;
  logic                         valid_q, valid_d;
  logic                         start_q, start_d;
  logic                         accept;
  logic                         load;

  function automatic logic signed [2:0] gray_level(input logic [1:0] g);
    case (g)
      2'b00:   return -3'sd3;
      2'b01:   return -3'sd1;
      2'b11:   return 3'sd1;
      default: return 3'sd3;
    endcase
  endfunction

  // Phase rotation of the fs/4 carrier: I, -Q, -I, +Q.
  function automatic logic signed [OUT_WIDTH-1:0] carrier_sample(input logic [3:0] sym,
                                                                 input logic [1:0] phase);
    logic signed [2:0]           lvl;
    logic signed [OUT_WIDTH-1:0] lvl_x;
    case (phase)
      2'd0:    lvl = gray_level(sym[3:2]);
      2'd1:    lvl = -gray_level(sym[1:0]);
      2'd2:    lvl = -gray_level(sym[3:2]);
      default: lvl = gray_level(sym[1:0]);
    endcase
    lvl_x = {{(OUT_WIDTH-3){lvl[2]}}, lvl};
    return lvl_x * SCALE_S;
  endfunction

  // Ready depends on registered state only.
  assign bit_ready = (bcnt_q != 2'd3) || !pend_full_q;
  assign accept    = bit_valid && bit_ready;

  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    shift_d     = shift_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    sym_d       = sym_q;
    scnt_d      = scnt_q;
    out_d       = '0;
    valid_d     = 1'b0;
    start_d     = 1'b0;
    load        = 1'b0;

    if (accept) begin
      shift_d = {shift_q[1:0], bit_in};
      bcnt_d  = bcnt_q + 2'd1;
      if (bcnt_q == 2'd3) begin
        pend_d      = {shift_q, bit_in};
        pend_full_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (pend_full_q) load = 1'b1;
      end
      RUN: begin
        out_d   = carrier_sample(sym_q, scnt_q[1:0]);
        valid_d = 1'b1;
        start_d = (scnt_q == '0);
        if (scnt_q == LAST_SAMPLE) begin
          if (pend_full_q) load = 1'b1;
          else             state_d = IDLE;
        end else begin
          scnt_d = scnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A load never coincides with a 4th-bit accept, since ready is low in that case.
    if (load) begin
      sym_d       = pend_q;
      pend_full_d = 1'b0;
      scnt_d      = '0;
      state_d     = RUN;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      bcnt_q      <= '0;
      shift_q     <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      sym_q       <= '0;
      scnt_q      <= '0;
      out_q       <= '0;
      valid_q     <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      sym_q       <= sym_d;
      scnt_q      <= scnt_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
      start_q     <= start_d;
    end
  end

  assign sample_out   = out_q;
  assign sample_valid = valid_q;
  assign symbol_start = start_q;

endmodule

// File: tb/tb_qam16_tx_modulator.sv
// Bench for qam16_tx_modulator: directed and random bit streams checked against a
// symbol-level model of the expected passband sample sequence.
module tb_qam16_tx_modulator;
  localparam int SPS = 8;
  localparam int SCALE = 32;
  localparam int OW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          bit_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic          bit_ready;
  logic [OW-1:0] sample_out;
  logic          sample_valid;
  logic          symbol_start;

  qam16_tx_modulator #(.SPS(SPS), .SCALE(SCALE), .OUT_WIDTH(OW)) dut (
    .clock(clock), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready), .sample_out(sample_out), .sample_valid(sample_valid),
    .symbol_start(symbol_start)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  int         obs_val[$];
  bit         obs_st[$];
  int         exp_q[$];
  logic [3:0] tx_q[$];
  int         runs = 0;
  int         stray = 0;
  bit         prev_v = 1'b0;

  always @(negedge clock) begin
    if (sample_valid === 1'b1) begin
      obs_val.push_back(int'($signed(sample_out)));
      obs_st.push_back(symbol_start);
      if (!prev_v) runs++;
    end else if (symbol_start === 1'b1) begin
      stray++;
    end
    prev_v = (sample_valid === 1'b1);
  end

  // Gray pair -> binary index -> level in {-3,-1,+1,+3}.
  function automatic int level(input logic [1:0] g);
    int b;
    b = 2 * int'(g[1]) + int'(g[1] ^ g[0]);
    return 2 * b - 3;
  endfunction

  function automatic int exp_sample(input logic [3:0] s, input int k);
    int i, q;
    i = level(s[3:2]);
    q = level(s[1:0]);
    case (k % 4)
      0:       return i * SCALE;
      1:       return -q * SCALE;
      2:       return -i * SCALE;
      default: return q * SCALE;
    endcase
  endfunction

  task automatic add_exp(input logic [3:0] s);
    for (int k = 0; k < SPS; k++) exp_q.push_back(exp_sample(s, k));
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_all();
    obs_val.delete();
    obs_st.delete();
    exp_q.delete();
    tx_q.delete();
  endtask

  // Drive the first nbits of tx_q; mode 0 continuous, 1 valid toggling, 2 random valid.
  task automatic send_stream(input int nbits, input int mode, output bit ok,
                             output int thr, output int rbad);
    int acc = 0;
    int guard = 0;
    bit tog = 1'b1;
    logic [3:0] s;
    ok = 1'b1; thr = 0; rbad = 0;
    while (acc < nbits && ok) begin
      s = tx_q[acc / 4];
      bit_in = s[3 - (acc % 4)];
      case (mode)
        0: bit_valid = 1'b1;
        1: begin bit_valid = tog; tog = !tog; end
        default: bit_valid = ($urandom_range(3, 0) != 0);
      endcase
      if (bit_ready !== 1'b1) begin
        thr++;
        if (acc % 4 != 3) rbad++;
      end
      if (bit_valid && bit_ready === 1'b1) acc++;
      step();
      guard++;
      if (guard > 64 * nbits) ok = 1'b0;
    end
    bit_valid = 1'b0;
  endtask

  task automatic wait_obs(input int n);
    int g = 0;
    while (obs_val.size() < n && g < 2000) begin step(); g++; end
    repeat (SPS + 4) step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) step();
    n_cmp++; if (sample_out !== '0) begin n_bad++; $display("FAIL reset_sample_out: got %0d want 0", sample_out); end
    n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL reset_sample_valid: got %b want 0", sample_valid); end
    n_cmp++; if (symbol_start !== 1'b0) begin n_bad++; $display("FAIL reset_symbol_start: got %b want 0", symbol_start); end
    n_cmp++; if (bit_ready !== 1'b1) begin n_bad++; $display("FAIL reset_bit_ready: got %b want 1", bit_ready); end
    reset = 1'b1;
    step();
    n_cmp++; if (bit_ready !== 1'b1 || sample_valid !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_idle: ready %b valid %b want 1 0", bit_ready, sample_valid); end
  endtask

  task automatic test_single(input logic [3:0] sym);
    bit ok; int thr, rbad;
    clear_all();
    tx_q.push_back(sym);
    send_stream(4, 0, ok, thr, rbad);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_send_timeout: sym %b not accepted", sym); end
    n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL single_lat1 sym %b: valid %b want 0", sym, sample_valid); end
    step();
    n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL single_lat2 sym %b: valid %b want 0", sym, sample_valid); end
    for (int k = 0; k < SPS; k++) begin
      step();
      n_cmp++;
      if (sample_valid !== 1'b1 || symbol_start !== (k == 0) ||
          int'($signed(sample_out)) != exp_sample(sym, k)) begin
        n_bad++;
        $display("FAIL single_sample sym %b k %0d: got %0d v%b s%b want %0d v1 s%0d",
                 sym, k, $signed(sample_out), sample_valid, symbol_start, exp_sample(sym, k), (k == 0));
      end
    end
    step();
    n_cmp++; if (sample_valid !== 1'b0 || sample_out !== '0) begin
      n_bad++; $display("FAIL single_end sym %b: got %0d v%b want 0 v0", sym, $signed(sample_out), sample_valid); end
    repeat (2) step();
  endtask

  task automatic test_back_to_back();
    bit ok; int thr, rbad; int r0;
    clear_all();
    tx_q.push_back(4'b1011); tx_q.push_back(4'b1011); tx_q.push_back(4'b0000);
    foreach (tx_q[i]) add_exp(tx_q[i]);
    r0 = runs;
    send_stream(12, 0, ok, thr, rbad);
    wait_obs(exp_q.size());
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_send_timeout: got timeout want completion"); end
    n_cmp++; if (thr == 0) begin n_bad++; $display("FAIL b2b_throttle: got %0d ready-low cycles want >0", thr); end
    n_cmp++; if (rbad != 0) begin n_bad++; $display("FAIL b2b_ready_low_wrong: got %0d want 0", rbad); end
    n_cmp++; if (runs - r0 != 1) begin n_bad++; $display("FAIL b2b_runs: got %0d want 1", runs - r0); end
    n_cmp++; if (obs_val.size() != exp_q.size()) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", obs_val.size(), exp_q.size()); end
    for (int j = 0; j < exp_q.size(); j++) begin
      n_cmp++;
      if (j >= obs_val.size() || obs_val[j] != exp_q[j] || obs_st[j] != (j % SPS == 0)) begin
        n_bad++;
        $display("FAIL b2b_sample[%0d]: got %0d s%0d want %0d s%0d", j,
                 (j < obs_val.size()) ? obs_val[j] : -999, (j < obs_st.size()) ? obs_st[j] : 0,
                 exp_q[j], (j % SPS == 0));
      end
    end
  endtask

  task automatic test_gappy_valid();
    bit ok; int thr, rbad;
    clear_all();
    tx_q.push_back(4'b0110); tx_q.push_back(4'b1001); tx_q.push_back(4'b1100);
    foreach (tx_q[i]) add_exp(tx_q[i]);
    send_stream(12, 1, ok, thr, rbad);
    wait_obs(exp_q.size());
    n_cmp++; if (!ok || rbad != 0) begin n_bad++; $display("FAIL gappy_send: ok %0d rbad %0d want 1 0", ok, rbad); end
    n_cmp++; if (obs_val.size() != exp_q.size()) begin n_bad++; $display("FAIL gappy_count: got %0d want %0d", obs_val.size(), exp_q.size()); end
    for (int j = 0; j < exp_q.size(); j++) begin
      n_cmp++;
      if (j >= obs_val.size() || obs_val[j] != exp_q[j] || obs_st[j] != (j % SPS == 0)) begin
        n_bad++;
        $display("FAIL gappy_sample[%0d]: got %0d want %0d", j,
                 (j < obs_val.size()) ? obs_val[j] : -999, exp_q[j]);
      end
    end
  endtask

  task automatic test_reset_mid_symbol();
    bit ok; int thr, rbad;
    clear_all();
    tx_q.push_back(4'b1011); tx_q.push_back(4'b0110); tx_q.push_back(4'b1111);
    send_stream(10, 0, ok, thr, rbad);
    step();
    n_cmp++; if (!ok || obs_val.size() != 6) begin
      n_bad++; $display("FAIL rstmid_pre: ok %0d samples %0d want 1 6", ok, obs_val.size()); end
    reset = 1'b0;
    step();
    n_cmp++; if (sample_valid !== 1'b0 || sample_out !== '0 || bit_ready !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_after: got v%b out %0d rdy %b want v0 out 0 rdy1", sample_valid, $signed(sample_out), bit_ready); end
    reset = 1'b1;
    clear_all();
    tx_q.push_back(4'b0001);
    add_exp(4'b0001);
    send_stream(4, 0, ok, thr, rbad);
    wait_obs(SPS);
    repeat (SPS) step();
    n_cmp++; if (!ok || obs_val.size() != SPS) begin
      n_bad++; $display("FAIL rstmid_fresh_count: ok %0d got %0d samples want %0d", ok, obs_val.size(), SPS); end
    for (int j = 0; j < SPS; j++) begin
      n_cmp++;
      if (j >= obs_val.size() || obs_val[j] != exp_q[j] || obs_st[j] != (j == 0)) begin
        n_bad++;
        $display("FAIL rstmid_sample[%0d]: got %0d want %0d", j,
                 (j < obs_val.size()) ? obs_val[j] : -999, exp_q[j]);
      end
    end
  endtask

  task automatic test_underrun();
    bit ok; int thr, rbad; int r0;
    logic [3:0] b;
    clear_all();
    b = 4'b0111;
    tx_q.push_back(4'b1110);
    add_exp(4'b1110);
    add_exp(b);
    r0 = runs;
    send_stream(4, 0, ok, thr, rbad);
    repeat (8) step();
    tx_q.delete();
    tx_q.push_back(b);
    send_stream(4, 0, ok, thr, rbad);
    n_cmp++; if (!ok || sample_valid !== 1'b0) begin n_bad++; $display("FAIL underrun_gap: ok %0d valid %b want 1 0", ok, sample_valid); end
    step();
    n_cmp++; if (sample_valid !== 1'b0) begin n_bad++; $display("FAIL underrun_lat2: valid %b want 0", sample_valid); end
    step();
    n_cmp++;
    if (sample_valid !== 1'b1 || symbol_start !== 1'b1 || int'($signed(sample_out)) != level(b[3:2]) * SCALE) begin
      n_bad++;
      $display("FAIL underrun_restart: got %0d v%b s%b want %0d v1 s1", $signed(sample_out), sample_valid,
               symbol_start, level(b[3:2]) * SCALE);
    end
    wait_obs(exp_q.size());
    n_cmp++; if (runs - r0 != 2) begin n_bad++; $display("FAIL underrun_runs: got %0d want 2", runs - r0); end
    n_cmp++; if (obs_val.size() != exp_q.size()) begin n_bad++; $display("FAIL underrun_count: got %0d want %0d", obs_val.size(), exp_q.size()); end
    for (int j = 0; j < exp_q.size(); j++) begin
      n_cmp++;
      if (j >= obs_val.size() || obs_val[j] != exp_q[j] || obs_st[j] != (j % SPS == 0)) begin
        n_bad++;
        $display("FAIL underrun_sample[%0d]: got %0d want %0d", j,
                 (j < obs_val.size()) ? obs_val[j] : -999, exp_q[j]);
      end
    end
  endtask

  task automatic test_random();
    bit ok; int thr, rbad;
    logic [3:0] s;
    clear_all();
    for (int i = 0; i < 16; i++) begin
      s = 4'($urandom_range(15, 0));
      tx_q.push_back(s);
      add_exp(s);
    end
    send_stream(64, 2, ok, thr, rbad);
    wait_obs(exp_q.size());
    n_cmp++; if (!ok || rbad != 0) begin n_bad++; $display("FAIL random_send: ok %0d rbad %0d want 1 0", ok, rbad); end
    n_cmp++; if (obs_val.size() != exp_q.size()) begin n_bad++; $display("FAIL random_count: got %0d want %0d", obs_val.size(), exp_q.size()); end
    for (int j = 0; j < exp_q.size(); j++) begin
      n_cmp++;
      if (j >= obs_val.size() || obs_val[j] != exp_q[j] || obs_st[j] != (j % SPS == 0)) begin
        n_bad++;
        $display("FAIL random_sample[%0d]: got %0d s%0d want %0d s%0d", j,
                 (j < obs_val.size()) ? obs_val[j] : -999, (j < obs_st.size()) ? obs_st[j] : 0,
                 exp_q[j], (j % SPS == 0));
      end
    end
    n_cmp++; if (stray != 0) begin n_bad++; $display("FAIL stray_symbol_start: got %0d want 0", stray); end
  endtask

  initial begin
    step();
    test_reset();
    test_single(4'b0000);
    test_single(4'b1011);
    test_single(4'b0110);
    test_back_to_back();
    repeat (4) step();
    test_gappy_valid();
    repeat (4) step();
    test_reset_mid_symbol();
    repeat (4) step();
    test_underrun();
    repeat (4) step();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
